// File: rtl/highlight_ctrl.sv
// Highlight coordinate owner: round-robin accepts one update into a shadow register
// and commits it to hl_* on the next vsync falling edge so the highlight never tears.
module highlight_ctrl #(
    parameter int X_MAX  = 639,
    parameter int Y_MAX  = 479,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [9:0] req0_x,
    input  logic [8:0] req0_y,
    input  logic       req0_en,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [9:0] req1_x,
    input  logic [8:0] req1_y,
    input  logic       req1_en,
    output logic [9:0] hl_x,
    output logic [8:0] hl_y,
    output logic       hl_en,
    output logic       commit,
    output logic       pending,
    output logic       last_src
);

    typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;

    state_t     state, state_next;
    logic       vsync_q;
    logic       vsync_fall;
    logic       ptr;
    logic       accept;
    logic       src;
    logic [9:0] shadow_x;
    logic [8:0] shadow_y;
    logic       shadow_en;

    function automatic logic [9:0] clamp_x(input logic [9:0] x);
        return (x > 10'(X_MAX)) ? 10'(X_MAX) : x;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] y);
        return (y > 9'(Y_MAX)) ? 9'(Y_MAX) : y;
    endfunction

    assign vsync_fall = vsync_q & ~vsync;
    assign pending    = (state == PENDING);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            vsync_q <= 1'b1;
        end else begin
            state   <= state_next;
            vsync_q <= vsync;
        end
    end

    // Arbiter is only live in IDLE; a vsync fall coinciding with an accept is ignored.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        src        = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !ptr)) begin
                    req0_ready = 1'b1;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                end
                accept = req0_ready | req1_ready;
                src    = req1_ready;
                if (accept) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (vsync_fall) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            hl_x      <= 10'(X_INIT);
            hl_y      <= 9'(Y_INIT);
            hl_en     <= 1'b1;
            commit    <= 1'b0;
            last_src  <= 1'b0;
            ptr       <= 1'b0;
            shadow_x  <= '0;
            shadow_y  <= '0;
            shadow_en <= 1'b0;
        end else begin
            commit <= (state == PENDING) && vsync_fall;
            if (accept) begin
                shadow_x  <= src ? clamp_x(req1_x) : clamp_x(req0_x);
                shadow_y  <= src ? clamp_y(req1_y) : clamp_y(req0_y);
                shadow_en <= src ? req1_en : req0_en;
                last_src  <= src;
                ptr       <= ~src;
            end
            if ((state == PENDING) && vsync_fall) begin
                hl_x  <= shadow_x;
                hl_y  <= shadow_y;
                hl_en <= shadow_en;
            end
        end
    end

endmodule

// File: tb/tb_highlight_ctrl.sv
// Bench for highlight_ctrl: directed scenarios with literal expectations, then random
// requesters and frame lengths checked every cycle against a frame-level reference model.
module tb_highlight_ctrl;

    localparam int X_MAX = 639, Y_MAX = 479, X_INIT = 320, Y_INIT = 240;

    logic       clk_pixel = 1'b0;
    logic       reset_n, vsync;
    logic       req0_valid, req0_ready, req0_en, req1_valid, req1_ready, req1_en;
    logic [9:0] req0_x, req1_x, hl_x;
    logic [8:0] req0_y, req1_y, hl_y;
    logic       hl_en, commit, pending, last_src;

    int vectors = 0;
    int fails = 0;

    always #5 clk_pixel = ~clk_pixel;

    highlight_ctrl #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT)) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .vsync(vsync),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_en(req0_en),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_en(req1_en),
        .hl_x(hl_x), .hl_y(hl_y), .hl_en(hl_en), .commit(commit), .pending(pending), .last_src(last_src)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference model: an update waits for the next frame boundary, then a one-cycle commit.
    int m_x, m_y, m_en, m_sx, m_sy, m_sen, m_ptr, m_last;
    bit m_wait, m_commit, m_vq, m_idle, m_r0, m_r1, m_fall;

    always @(negedge clk_pixel) begin
        if (!reset_n) begin
            m_x = X_INIT; m_y = Y_INIT; m_en = 1; m_sx = 0; m_sy = 0; m_sen = 0;
            m_ptr = 0; m_last = 0; m_wait = 0; m_commit = 0; m_vq = 1;
        end
        m_idle = !m_wait && !m_commit;
        m_r0 = m_idle && req0_valid && (!req1_valid || m_ptr == 0);
        m_r1 = m_idle && req1_valid && (!req0_valid || m_ptr == 1);
        chk("req0_ready", req0_ready, m_r0);
        chk("req1_ready", req1_ready, m_r1);
        chk("hl_x", hl_x, m_x);
        chk("hl_y", hl_y, m_y);
        chk("hl_en", hl_en, m_en);
        chk("commit", commit, m_commit);
        chk("pending", pending, m_wait);
        chk("last_src", last_src, m_last);
        if (reset_n) begin
            m_fall = m_vq && !vsync;
            if (m_commit) begin
                m_commit = 0;
            end else if (m_wait) begin
                if (m_fall) begin
                    m_x = m_sx; m_y = m_sy; m_en = m_sen;
                    m_wait = 0; m_commit = 1;
                end
            end else if (m_r0 || m_r1) begin
                m_sx   = clampv(m_r1 ? int'(req1_x) : int'(req0_x), X_MAX);
                m_sy   = clampv(m_r1 ? int'(req1_y) : int'(req0_y), Y_MAX);
                m_sen  = m_r1 ? int'(req1_en) : int'(req0_en);
                m_last = m_r1 ? 1 : 0;
                m_ptr  = m_r1 ? 0 : 1;
                m_wait = 1;
            end
            m_vq = vsync;
        end
    end

    // Stimulus: frame counter drives vsync (low for the first two cycles of each frame).
    int fcnt = 2;
    int flen = 16;
    bit rand_frames = 0;
    bit a0, a1;

    task automatic step();
        @(negedge clk_pixel);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk_pixel);
        #1;
        if (a0) req0_valid = 1'b0;
        if (a1) req1_valid = 1'b0;
        fcnt++;
        if (fcnt >= flen) begin
            fcnt = 0;
            if (rand_frames) flen = $urandom_range(8, 40);
        end
        vsync = (fcnt >= 2);
    endtask

    task automatic wait_fcnt(input int target);
        for (int i = 0; i < 200 && fcnt != target; i++) step();
        chk("wait_fcnt", fcnt, target);
    endtask

    task automatic drive0(input int x, input int y, input bit en);
        req0_x = 10'(x); req0_y = 9'(y); req0_en = en; req0_valid = 1'b1;
    endtask

    task automatic drive1(input int x, input int y, input bit en);
        req1_x = 10'(x); req1_y = 9'(y); req1_en = en; req1_valid = 1'b1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; vsync = 1'b1;
        req0_valid = 0; req0_x = 0; req0_y = 0; req0_en = 0;
        req1_valid = 0; req1_x = 0; req1_y = 0; req1_en = 0;
        repeat (3) @(posedge clk_pixel);
        #1 reset_n = 1'b1;

        chk("rst_hl_x", hl_x, 320);
        chk("rst_hl_y", hl_y, 240);
        chk("rst_hl_en", hl_en, 1);
        chk("rst_commit", commit, 0);
        chk("rst_pending", pending, 0);
        chk("rst_readies", {req0_ready, req1_ready}, 0);

        // Single request mid-frame, commit at the next vsync fall.
        wait_fcnt(5);
        drive0(100, 50, 1);
        #1 chk("t2_ready", req0_ready, 1);
        step();
        chk("t2_accepted", a0, 1);
        chk("t2_pending", pending, 1);
        chk("t2_hold_x", hl_x, 320);
        wait_fcnt(1);
        chk("t2_hl_x", hl_x, 100);
        chk("t2_hl_y", hl_y, 50);
        chk("t2_commit", commit, 1);
        step();
        chk("t2_commit_drop", commit, 0);

        // Out-of-range request clamps.
        wait_fcnt(5);
        drive1(1023, 511, 0);
        wait_fcnt(1);
        chk("t4_hl_x", hl_x, 639);
        chk("t4_hl_y", hl_y, 479);
        chk("t4_hl_en", hl_en, 0);
        chk("t4_last_src", last_src, 1);

        // Both requesters held valid: accepts alternate 0,1,0.
        wait_fcnt(5);
        drive0(10, 20, 1);
        drive1(30, 40, 1);
        n = 0;
        for (int i = 0; i < 300 && n < 3; i++) begin
            step();
            if (a0 || a1) begin
                chk("t3_src", a1, (n == 1));
                chk("t3_last_src", last_src, (n == 1));
                n++;
                if (n < 3) begin
                    if (a0) drive0(11 + n, 21 + n, 1);
                    else    drive1(31 + n, 41 + n, 0);
                end
            end
        end
        chk("t3_accepts", n, 3);
        for (int i = 0; i < 300 && (req0_valid || req1_valid); i++) step();
        chk("t3_drained", {req0_valid, req1_valid}, 0);
        wait_fcnt(3);
        wait_fcnt(1);
        wait_fcnt(3);

        // Accept in the same cycle as a vsync fall: commit waits a frame.
        wait_fcnt(0);
        drive0(7, 9, 1);
        #1 chk("t5_ready", req0_ready, 1);
        step();
        chk("t5_accepted", a0, 1);
        wait_fcnt(5);
        chk("t5_still_pending", pending, 1);
        wait_fcnt(1);
        chk("t5_hl_x", hl_x, 7);
        chk("t5_hl_y", hl_y, 9);
        chk("t5_commit", commit, 1);

        // Reset while an update is pending discards it.
        wait_fcnt(5);
        drive0(200, 100, 1);
        step();
        chk("t6_pending", pending, 1);
        #2 reset_n = 1'b0;
        req0_valid = 1'b0;
        #1;
        chk("t6_hl_x", hl_x, 320);
        chk("t6_hl_y", hl_y, 240);
        chk("t6_hl_en", hl_en, 1);
        chk("t6_pending", pending, 0);
        chk("t6_commit", commit, 0);
        chk("t6_last_src", last_src, 0);
        step();
        step();
        reset_n = 1'b1;
        wait_fcnt(1);
        wait_fcnt(5);
        chk("t6_no_commit_x", hl_x, 320);
        chk("t6_no_pending", pending, 0);

        // Random requesters and frame lengths.
        rand_frames = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid && $urandom_range(0, 3) == 0)
                drive0($urandom_range(0, 1023), $urandom_range(0, 511), 1'($urandom_range(0, 1)));
            if (!req1_valid && $urandom_range(0, 3) == 0)
                drive1($urandom_range(0, 1023), $urandom_range(0, 511), 1'($urandom_range(0, 1)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
